// File: rtl/accel_pkg.sv
// Shared accelerator definitions: stream-reader FSM encoding and frame buffer geometry.
package accel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam int FRAME_DEPTH = 12672;
   localparam int PIX_WIDTH   = 24;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry output buffer; a push into a full FIFO is accepted only alongside a pop.
module stream_fifo2 #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [1:0]   occ
);

   logic [1:0][W-1:0] mem_q, mem_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              do_push, do_pop;

   assign full    = (cnt_q == 2'd2);
   assign empty   = (cnt_q == 2'd0);
   assign occ     = cnt_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q ^ do_push;
      rd_ptr_d = rd_ptr_q ^ do_pop;
      cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
      if (do_push) mem_d[wr_ptr_q] = din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads len words from BRAM address 0 and streams them out as an AXI4-Stream master.
module bram_stream_reader
   import accel_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = PIX_WIDTH,
   parameter int DEPTH      = FRAME_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic                  bram_ce,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_rdata,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   localparam int CW = ADDR_WIDTH + 1;

   state_t        state_q, state_d;
   logic [CW-1:0] len_q, len_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic          rd_pending_q, rd_pending_d;
   logic          fifo_full, fifo_empty;
   logic [1:0]    fifo_occ;
   logic          pop;
   logic [2:0]    inflight;
   logic [CW-1:0] len_clamped;

   // A beat leaving this cycle frees a slot, so reads keep flowing at one per cycle.
   assign pop      = m_axis_tvalid & m_axis_tready;
   assign inflight = {1'b0, fifo_occ} + {2'b0, rd_pending_q} - {2'b0, pop};
   assign bram_ce  = (state_q == ST_RUN) && (rd_cnt_q < len_q) && (inflight < 3'd2);
   assign bram_we  = 1'b0;
   assign bram_addr = rd_cnt_q[ADDR_WIDTH-1:0];

   assign m_axis_tvalid = ~fifo_empty;
   assign m_axis_tlast  = m_axis_tvalid && (out_cnt_q == len_q - CW'(1));
   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_FINISH);

   assign len_clamped = (len > CW'(DEPTH)) ? CW'(DEPTH) : len;

   stream_fifo2 #(.W(DATA_WIDTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rd_pending_q),
      .din   (bram_rdata),
      .pop   (pop),
      .dout  (m_axis_tdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .occ   (fifo_occ)
   );

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      rd_cnt_d     = rd_cnt_q;
      out_cnt_d    = out_cnt_q;
      rd_pending_d = bram_ce;
      case (state_q)
         ST_IDLE: if (start) begin
            len_d     = len_clamped;
            rd_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = (len == '0) ? ST_FINISH : ST_RUN;
         end
         ST_RUN: begin
            if (bram_ce) rd_cnt_d = rd_cnt_q + CW'(1);
            if (pop)     out_cnt_d = out_cnt_q + CW'(1);
            if (pop && m_axis_tlast) state_d = ST_FINISH;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         rd_cnt_q     <= '0;
         out_cnt_q    <= '0;
         rd_pending_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         rd_cnt_q     <= rd_cnt_d;
         out_cnt_q    <= out_cnt_d;
         rd_pending_q <= rd_pending_d;
      end
   end

   logic unused_ok;
   assign unused_ok = fifo_full;

endmodule
